lsu_byte_mem_ctrl: RTL and testbench
====================================

// Module: lsu_byte_mem_ctrl
// PURPOSE
//  Load/store initiator between the CPU MEM stage and the dual-port byte data RAM (two 8-bit ports,
//  1-cycle registered read). Turns one LB/LBU/LH/LHU/LW/SB/SH/SW request into 1 or 2 two-byte RAM
//  beats, assembles little-endian read data with sign/zero extension and returns a single response.
//  Misaligned, bad-size and out-of-range requests are rejected without touching memory.
// PARAMETERS
//  MEM_BYTES  32768  RAM depth in bytes; valid byte index 0..MEM_BYTES-1
//  ADDR_BASE  0      CPU address of RAM byte 0; idx = req_addr - ADDR_BASE (32-bit unsigned)
// PORTS
//  clk           in   1   clock, all state on posedge
//  rst           in   1   asynchronous, active-high reset
//  req_valid     in   1   request present
//  req_ready     out  1   1 only in IDLE; accept = req_valid & req_ready at posedge
//  req_we        in   1   1=store, 0=load
//  req_size      in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned  in   1   loads: 1=zero-extend (LBU/LHU), 0=sign-extend
//  req_addr      in   32  CPU byte address
//  req_wdata     in   32  store data, byte0 = [7:0]
//  resp_valid    out  1   one-cycle response pulse, no backpressure
//  resp_err      out  1   valid with resp_valid; 1 = rejected, no memory access done
//  resp_rdata    out  32  load result; 0 for stores and errors
//  mem_we1/2     out  1   RAM port 1/2 write enable
//  mem_addr1/2   out  32  RAM port 1/2 byte index
//  mem_wdata1/2  out  8   RAM port 1/2 write byte
//  mem_rdata1/2  in   8   RAM port 1/2 read byte (registered inside RAM, 1 cycle after address)
// BEHAVIOUR
//  - Reset (async): state=IDLE, resp_valid=0, resp_err=0, resp_rdata=0, request regs=0.
//    mem_* outputs decode from state, so mem_we1/2 fall in the same cycle rst rises.
//  - States: IDLE, LO, HI, CAPT, RESP. Accept latches we/size/unsigned/idx/wdata.
//  - Checks at accept: err if size==11, idx[0]!=0 for half, idx[1:0]!=0 for word,
//    or idx+bytes-1 >= MEM_BYTES. On err: IDLE->RESP (resp_err=1, rdata=0), no mem_we ever.
//  - Legal: IDLE->LO; LO->HI if word else CAPT; HI->CAPT; CAPT->RESP; RESP->IDLE.
//    Resp_valid timing from accept cycle A: byte/half A+3, word A+4, error A+1.
//  - LO: addr1=idx, addr2=idx+1; wdata1=wdata[7:0], wdata2=wdata[15:8];
//    we1=req_we; we2=req_we & (size!=byte).
//  - HI (word only): addr1=idx+2, addr2=idx+3, wdata1=[23:16], wdata2=[31:24],
//    we1=we2=req_we. Latch LO read bytes (mem_rdata1/2) into b0/b1 at end of HI.
//  - CAPT: latch mem_rdata1/2 into b0/b1 (byte/half) or b2/b3 (word).
//    Register resp_rdata: byte {24{ext}},b0; half {16{ext}},b1,b0; word b3,b2,b1,b0.
//    ext = req_unsigned ? 0 : MSB of top byte read. Stores: resp_rdata=0.
//  - IDLE/CAPT/RESP: mem_we1/2=0, mem_addr1/2=0, mem_wdata1/2=0.
//  - resp_valid/resp_err high only in RESP, registered; cleared on entering IDLE.
//    resp_rdata holds until next response.
//  - req_valid outside IDLE ignored (req_ready=0); back-to-back accept on first cycle after RESP.
//  - Reset mid-op: abort to IDLE, no response. Bytes already written in LO stay written (no rollback).
//  - Index math 32-bit wrap-free: range check done before any beat, so idx+3 never exceeds MEM_BYTES-1.
// TESTING
//  1. mem[0x10..0x13]=78,56,34,12; LW 0x10 accepted at A -> resp_valid @A+4, rdata=0x12345678, err=0.
//  2. mem[0x13]=0x80: LB 0x13 -> 0xFFFFFF80; LBU -> 0x00000080.
//     mem[0x12..0x13]=FF,80: LH 0x12 -> 0xFFFF80FF; LHU -> 0x000080FF.
//  3. SW 0xDEADBEEF @0x20 -> LO: we1/we2, addr 0x20/0x21, data EF/BE; HI: addr 0x22/0x23, data AD/DE.
//     Then LW 0x20 -> 0xDEADBEEF.
//  4. SB 0xAA @0x05 -> only we1 asserted; mem[0x05]=AA, mem[0x06] unchanged.
//  5. SH @0x21, LW @0x7FFE, size=11 -> resp_err=1 @A+1, rdata=0, mem_we1/2 never high.
//  6. rst asserted during HI of SW @0x30 -> mem_we drops same cycle, no resp_valid.
//     After release req_ready=1; 0x30/0x31 written, 0x32/0x33 old. req_valid held while busy is ignored.

Source files
------------

// File: rtl/lsu_byte_mem_ctrl.sv
// Load/store initiator for a dual-port byte RAM: splits LB/LH/LW/SB/SH/SW into
// one or two two-byte beats and returns a single sign/zero-extended response.
module lsu_byte_mem_ctrl #(
  parameter int unsigned MEM_BYTES = 32768,
  parameter logic [31:0] ADDR_BASE = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic        o_resp_err,
  output logic [31:0] o_resp_rdata,
  output logic        o_mem_we1,
  output logic        o_mem_we2,
  output logic [31:0] o_mem_addr1,
  output logic [31:0] o_mem_addr2,
  output logic [7:0]  o_mem_wdata1,
  output logic [7:0]  o_mem_wdata2,
  input  logic [7:0]  i_mem_rdata1,
  input  logic [7:0]  i_mem_rdata2
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_CAPT,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_idx;
  logic [31:0] r_wdata;
  logic [7:0]  r_b0;
  logic [7:0]  r_b1;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;

  logic [31:0] w_idx;
  logic [1:0]  w_bytes_m1;
  logic [32:0] w_last;
  logic        w_align_err;
  logic        w_range_err;
  logic        w_req_err;
  logic        w_ext_b;
  logic        w_ext_h;
  logic [31:0] w_capt_rdata;

  // Range check in 33 bits so a request near 2^32 cannot wrap back into range.
  assign w_idx       = i_req_addr - ADDR_BASE;
  assign w_bytes_m1  = (i_req_size == 2'b01) ? 2'd1 :
                       (i_req_size == 2'b10) ? 2'd3 : 2'd0;
  assign w_last      = {1'b0, w_idx} + {31'b0, w_bytes_m1};
  assign w_range_err = (w_last >= 33'(MEM_BYTES));
  assign w_align_err = ((i_req_size == 2'b01) && w_idx[0]) ||
                       ((i_req_size == 2'b10) && (w_idx[1:0] != 2'b00));
  assign w_req_err   = (i_req_size == 2'b11) || w_align_err || w_range_err;

  assign o_req_ready  = (r_state == S_IDLE);
  assign o_resp_valid = r_resp_valid;
  assign o_resp_err   = r_resp_err;
  assign o_resp_rdata = r_resp_rdata;

  always_comb begin
    w_state_next = r_state;
    o_mem_we1    = 1'b0;
    o_mem_we2    = 1'b0;
    o_mem_addr1  = 32'h0;
    o_mem_addr2  = 32'h0;
    o_mem_wdata1 = 8'h0;
    o_mem_wdata2 = 8'h0;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          w_state_next = w_req_err ? S_RESP : S_LO;
        end
      end
      S_LO: begin
        w_state_next = (r_size == 2'b10) ? S_HI : S_CAPT;
        o_mem_we1    = r_we;
        o_mem_we2    = r_we && (r_size != 2'b00);
        o_mem_addr1  = r_idx;
        o_mem_addr2  = r_idx + 32'd1;
        o_mem_wdata1 = r_wdata[7:0];
        o_mem_wdata2 = r_wdata[15:8];
      end
      S_HI: begin
        w_state_next = S_CAPT;
        o_mem_we1    = r_we;
        o_mem_we2    = r_we;
        o_mem_addr1  = r_idx + 32'd2;
        o_mem_addr2  = r_idx + 32'd3;
        o_mem_wdata1 = r_wdata[23:16];
        o_mem_wdata2 = r_wdata[31:24];
      end
      S_CAPT: w_state_next = S_RESP;
      S_RESP: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // In CAPT the RAM is presenting the last beat's bytes; earlier word bytes sit in b0/b1.
  assign w_ext_b = ~r_unsigned & i_mem_rdata1[7];
  assign w_ext_h = ~r_unsigned & i_mem_rdata2[7];

  always_comb begin
    w_capt_rdata = 32'h0;
    if (!r_we) begin
      case (r_size)
        2'b00:   w_capt_rdata = {{24{w_ext_b}}, i_mem_rdata1};
        2'b01:   w_capt_rdata = {{16{w_ext_h}}, i_mem_rdata2, i_mem_rdata1};
        2'b10:   w_capt_rdata = {i_mem_rdata2, i_mem_rdata1, r_b1, r_b0};
        default: w_capt_rdata = 32'h0;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_idx        <= 32'h0;
      r_wdata      <= 32'h0;
      r_b0         <= 8'h0;
      r_b1         <= 8'h0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'h0;
    end else begin
      r_state      <= w_state_next;
      r_resp_valid <= (w_state_next == S_RESP);
      r_resp_err   <= (r_state == S_IDLE) && (w_state_next == S_RESP);
      if ((r_state == S_IDLE) && i_req_valid) begin
        r_we       <= i_req_we;
        r_size     <= i_req_size;
        r_unsigned <= i_req_unsigned;
        r_idx      <= w_idx;
        r_wdata    <= i_req_wdata;
        if (w_req_err) begin
          r_resp_rdata <= 32'h0;
        end
      end
      if (r_state == S_HI) begin
        r_b0 <= i_mem_rdata1;
        r_b1 <= i_mem_rdata2;
      end
      if (r_state == S_CAPT) begin
        r_resp_rdata <= w_capt_rdata;
      end
    end
  end

endmodule

// File: tb/tb_lsu_byte_mem_ctrl.sv
// Bench for lsu_byte_mem_ctrl: byte RAM model, queued expected responses and a
// monitor that checks each response and records every write beat.
module tb_lsu_byte_mem_ctrl;

  localparam int unsigned MEM_BYTES = 32768;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we1, mem_we2;
  logic [31:0] mem_addr1, mem_addr2;
  logic [7:0]  mem_wdata1, mem_wdata2;
  logic [7:0]  mem_rdata1, mem_rdata2;

  lsu_byte_mem_ctrl #(.MEM_BYTES(MEM_BYTES), .ADDR_BASE(32'h0)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_we(req_we), .i_req_size(req_size), .i_req_unsigned(req_unsigned),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_resp_valid(resp_valid), .o_resp_err(resp_err), .o_resp_rdata(resp_rdata),
    .o_mem_we1(mem_we1), .o_mem_we2(mem_we2),
    .o_mem_addr1(mem_addr1), .o_mem_addr2(mem_addr2),
    .o_mem_wdata1(mem_wdata1), .o_mem_wdata2(mem_wdata2),
    .i_mem_rdata1(mem_rdata1), .i_mem_rdata2(mem_rdata2)
  );

  always #5 clk = ~clk;

  // RAM model: registered read, write-through not visible on the same cycle.
  logic [7:0]  mem [0:MEM_BYTES-1];
  logic        pl_en = 1'b0;
  logic [14:0] pl_addr = 15'h0;
  logic [7:0]  pl_data = 8'h0;

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else begin
      if (mem_addr1 < 32'(MEM_BYTES)) begin
        if (mem_we1) mem[mem_addr1[14:0]] <= mem_wdata1;
        mem_rdata1 <= mem[mem_addr1[14:0]];
      end
      if (mem_addr2 < 32'(MEM_BYTES)) begin
        if (mem_we2) mem[mem_addr2[14:0]] <= mem_wdata2;
        mem_rdata2 <= mem[mem_addr2[14:0]];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        we1;
    logic        we2;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [7:0]  d1;
    logic [7:0]  d2;
  } beat_t;

  exp_t  sb[$];
  beat_t beats[$];
  int    n_checks = 0;
  int    n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compares responses in order and logs write beats.
  initial begin
    exp_t  e;
    beat_t b;
    forever begin
      @(posedge clk);
      #1;
      if (resp_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_resp: got err=%0d rdata=0x%08h, expected no response", resp_err, resp_rdata);
        end else begin
          e = sb.pop_front();
          check({e.name, "_err"}, {31'b0, resp_err}, {31'b0, e.err});
          check({e.name, "_rdata"}, resp_rdata, e.rdata);
          check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
        end
      end
      if (mem_we1 || mem_we2) begin
        b.we1 = mem_we1; b.we2 = mem_we2;
        b.a1 = mem_addr1; b.a2 = mem_addr2;
        b.d1 = mem_wdata1; b.d2 = mem_wdata2;
        beats.push_back(b);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic poke(input logic [14:0] a, input logic [7:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_ready_wait", {31'b0, req_ready}, 32'h1);
  endtask

  task automatic idle();
    wait_ready();
    req_valid = 1'b0;
  endtask

  // Sets up the request at #1 after an edge; it is accepted on the next edge,
  // so the response is due lat edges later. A junk store stays asserted while busy.
  task automatic issue(input string name, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] exp_rdata, input int lat);
    exp_t e;
    wait_ready();
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    e.name = name; e.err = exp_err; e.rdata = exp_rdata; e.cyc = cyc + lat;
    sb.push_back(e);
    @(posedge clk); #1;
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h5555_5555;
  endtask

  task automatic check_beat(input string name, input logic [1:0] we,
                            input logic [31:0] a1, input logic [31:0] a2,
                            input logic [7:0] d1, input logic [7:0] d2);
    beat_t b;
    if (beats.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_beat: got no write beat, expected one", name);
    end else begin
      b = beats.pop_front();
      check({name, "_we"}, {30'b0, b.we1, b.we2}, {30'b0, we});
      check({name, "_addr1"}, b.a1, a1);
      check({name, "_addr2"}, b.a2, a2);
      check({name, "_data"}, {16'b0, b.d1, b.d2}, {16'b0, d1, d2});
    end
  endtask

  initial begin
    #3;
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_resp_err", {31'b0, resp_err}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_we", {30'b0, mem_we1, mem_we2}, 32'h0);
    check("rst_req_ready", {31'b0, req_ready}, 32'h1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    poke(15'h10, 8'h78); poke(15'h11, 8'h56); poke(15'h12, 8'h34); poke(15'h13, 8'h12);
    poke(15'h50, 8'h34); poke(15'h51, 8'h12); poke(15'h52, 8'hFF); poke(15'h53, 8'h80);
    poke(15'h06, 8'h66);
    poke(15'h30, 8'hA0); poke(15'h31, 8'hA1); poke(15'h32, 8'hA2); poke(15'h33, 8'hA3);
    poke(15'h7FFC, 8'h01); poke(15'h7FFD, 8'h02); poke(15'h7FFE, 8'h03); poke(15'h7FFF, 8'h84);

    // Loads, with sign and zero extension.
    issue("lw_10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h1234_5678, 4);
    issue("lb_53",  1'b0, 2'b00, 1'b0, 32'h53, 32'h0, 1'b0, 32'hFFFF_FF80, 3);
    issue("lbu_53", 1'b0, 2'b00, 1'b1, 32'h53, 32'h0, 1'b0, 32'h0000_0080, 3);
    issue("lh_52",  1'b0, 2'b01, 1'b0, 32'h52, 32'h0, 1'b0, 32'hFFFF_80FF, 3);
    issue("lhu_52", 1'b0, 2'b01, 1'b1, 32'h52, 32'h0, 1'b0, 32'h0000_80FF, 3);
    issue("lh_50",  1'b0, 2'b01, 1'b0, 32'h50, 32'h0, 1'b0, 32'h0000_1234, 3);
    issue("lb_52",  1'b0, 2'b00, 1'b0, 32'h52, 32'h0, 1'b0, 32'hFFFF_FFFF, 3);
    issue("lb_51",  1'b0, 2'b00, 1'b0, 32'h51, 32'h0, 1'b0, 32'h0000_0012, 3);
    idle();
    check("load_no_writes", 32'(beats.size()), 32'h0);

    // Word and half stores, then read back.
    issue("sw_20", 1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, 1'b0, 32'h0, 4);
    idle();
    check_beat("sw_20_lo", 2'b11, 32'h20, 32'h21, 8'hEF, 8'hBE);
    check_beat("sw_20_hi", 2'b11, 32'h22, 32'h23, 8'hAD, 8'hDE);
    check("sw_20_beats", 32'(beats.size()), 32'h0);
    issue("sh_24", 1'b1, 2'b01, 1'b0, 32'h24, 32'h1234_CAFE, 1'b0, 32'h0, 3);
    idle();
    check_beat("sh_24", 2'b11, 32'h24, 32'h25, 8'hFE, 8'hCA);
    issue("lhu_24", 1'b0, 2'b01, 1'b1, 32'h24, 32'h0, 1'b0, 32'h0000_CAFE, 3);
    issue("lh_24",  1'b0, 2'b01, 1'b0, 32'h24, 32'h0, 1'b0, 32'hFFFF_CAFE, 3);
    issue("lw_20",  1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'hDEAD_BEEF, 4);
    idle();

    // Reset in the HI beat of a word store: first beat stays written, no response.
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h30; req_wdata = 32'h1122_3344; req_valid = 1'b1;
    @(posedge clk); #1;
    req_addr = 32'h40; req_wdata = 32'h5555_5555;
    @(posedge clk); #1;
    check("abort_hi_we", {30'b0, mem_we1, mem_we2}, 32'h3);
    check("abort_hi_addr1", mem_addr1, 32'h32);
    rst = 1'b1;
    #1;
    check("abort_we_drop", {30'b0, mem_we1, mem_we2}, 32'h0);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    check("abort_ready", {31'b0, req_ready}, 32'h1);
    check("abort_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("abort_rdata_cleared", resp_rdata, 32'h0);
    repeat (6) @(posedge clk);
    #1;
    check("abort_mem30", {24'b0, mem[15'h30]}, 32'h44);
    check("abort_mem31", {24'b0, mem[15'h31]}, 32'h33);
    check("abort_mem32", {24'b0, mem[15'h32]}, 32'hA2);
    check("abort_mem33", {24'b0, mem[15'h33]}, 32'hA3);
    beats.delete();

    // Byte store touches only port 1.
    issue("sb_05", 1'b1, 2'b00, 1'b0, 32'h05, 32'h1234_56AA, 1'b0, 32'h0, 3);
    idle();
    check_beat("sb_05", 2'b10, 32'h05, 32'h06, 8'hAA, 8'h56);
    check("sb_05_beats", 32'(beats.size()), 32'h0);
    check("sb_05_mem05", {24'b0, mem[15'h05]}, 32'hAA);
    check("sb_05_mem06", {24'b0, mem[15'h06]}, 32'h66);
    issue("lbu_05", 1'b0, 2'b00, 1'b1, 32'h05, 32'h0, 1'b0, 32'h0000_00AA, 3);

    // Rejections and edge-of-memory accesses.
    issue("lw_7ffc",  1'b0, 2'b10, 1'b0, 32'h7FFC, 32'h0, 1'b0, 32'h8403_0201, 4);
    issue("sh_21",    1'b1, 2'b01, 1'b0, 32'h21, 32'hFFFF_FFFF, 1'b1, 32'h0, 1);
    issue("lb_7fff",  1'b0, 2'b00, 1'b0, 32'h7FFF, 32'h0, 1'b0, 32'hFFFF_FF84, 3);
    issue("lw_7ffe",  1'b0, 2'b10, 1'b0, 32'h7FFE, 32'h0, 1'b1, 32'h0, 1);
    issue("size_11",  1'b1, 2'b11, 1'b0, 32'h00, 32'hFFFF_FFFF, 1'b1, 32'h0, 1);
    issue("sw_8000",  1'b1, 2'b10, 1'b0, 32'h8000, 32'hFFFF_FFFF, 1'b1, 32'h0, 1);
    issue("lb_8000",  1'b0, 2'b00, 1'b0, 32'h8000, 32'h0, 1'b1, 32'h0, 1);
    issue("sb_ffffffff", 1'b1, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0, 1);
    issue("lhu_7ffe", 1'b0, 2'b01, 1'b1, 32'h7FFE, 32'h0, 1'b0, 32'h0000_8403, 3);
    idle();
    check("err_no_writes", 32'(beats.size()), 32'h0);
    check("sh_21_untouched", {24'b0, mem[15'h21]}, 32'hBE);

    repeat (8) @(posedge clk);
    #1;
    check("pending_responses", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
